cr_crcgc_ob_buf: RTL and testbench

- Output elastic buffer directly downstream of the CRC generate/check stage.
- Absorbs the CRC stage's outbound 64-bit AXI4-stream beats and decouples it from next-stage backpressure.
- Optionally holds a frame until its tlast beat has been buffered (store-and-forward).
- Reports fill level and per-frame/stall stat pulses for the stats block.

---
 rtl/cr_crcgc_ob_buf.sv | 144 ++++++++++++++
 tb/tb_cr_crcgc_ob_buf.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/cr_crcgc_ob_buf.sv
// Output elastic buffer after the CRC generate/check stage: cut-through or store-and-forward,
// with fill level and stat pulses. Define CR_CRCGC_OB_BUF_WATERMARK_EN to add the hwm/hwm_clr ports.
module cr_crcgc_ob_buf #(
    parameter int unsigned DEPTH = 8,
    localparam int unsigned AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sf_mode,
    input  logic          in_tvalid,
    input  logic          in_tlast,
    input  logic [7:0]    in_tuser,
    input  logic [7:0]    in_tstrb,
    input  logic [63:0]   in_tdata,
    output logic          in_tready,
    output logic          out_tvalid,
    output logic          out_tlast,
    output logic [7:0]    out_tuser,
    output logic [7:0]    out_tstrb,
    output logic [63:0]   out_tdata,
    input  logic          out_tready,
    output logic [AW:0]   fill_level,
    output logic          stat_frame_out,
    output logic          stat_stall
`ifdef CR_CRCGC_OB_BUF_WATERMARK_EN
    ,
    input  logic          hwm_clr,
    output logic [AW:0]   hwm
`endif
);

    typedef enum logic {IDLE, XFER} state_t;

    localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   ONE  = (AW+1)'(1);
    localparam int unsigned   BW   = 81;

    logic [BW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d, frame_cnt_q, frame_cnt_d;
    state_t        state_q, state_d;
    logic          mode_q, mode_d;
    logic          push, pop, eligible, frame_in, frame_out;

    always_comb begin
        in_tready = (count_q != FULL);
        {out_tlast, out_tuser, out_tstrb, out_tdata} = mem_q[rd_ptr_q];
        // Full override lets store-and-forward release frames longer than DEPTH.
        eligible   = (count_q != '0) && (!mode_q || (frame_cnt_q != '0) || (count_q == FULL));
        state_d    = state_q;
        mode_d     = mode_q;
        out_tvalid = 1'b0;
        case (state_q)
            IDLE: begin
                out_tvalid = eligible;
                if (!eligible) begin
                    mode_d = sf_mode;
                end else if (!(out_tready && out_tlast)) begin
                    state_d = XFER;
                end
            end
            XFER: begin
                out_tvalid = (count_q != '0);
                if (out_tvalid && out_tready && out_tlast) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        push      = in_tvalid && in_tready;
        pop       = out_tvalid && out_tready;
        frame_in  = push && in_tlast;
        frame_out = pop && out_tlast;

        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + ONE;
        end else if (pop && !push) begin
            count_d = count_q - ONE;
        end

        frame_cnt_d = frame_cnt_q;
        if (frame_in && !frame_out) begin
            frame_cnt_d = frame_cnt_q + ONE;
        end else if (frame_out && !frame_in) begin
            frame_cnt_d = frame_cnt_q - ONE;
        end

        fill_level     = count_q;
        stat_frame_out = frame_out;
        stat_stall     = out_tvalid && !out_tready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            frame_cnt_q <= '0;
            state_q     <= IDLE;
            mode_q      <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            frame_cnt_q <= frame_cnt_d;
            state_q     <= state_d;
            mode_q      <= mode_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_tlast, in_tuser, in_tstrb, in_tdata};
        end
    end

`ifdef CR_CRCGC_OB_BUF_WATERMARK_EN
    logic [AW:0] hwm_q, hwm_d;

    always_comb begin
        hwm_d = hwm_q;
        if (hwm_clr) begin
            hwm_d = '0;
        end else if (count_q > hwm_q) begin
            hwm_d = count_q;
        end
        hwm = hwm_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hwm_q <= '0;
        end else begin
            hwm_q <= hwm_d;
        end
    end
`endif

endmodule

// File: tb/tb_cr_crcgc_ob_buf.sv
// Directed self-checking bench for cr_crcgc_ob_buf (DEPTH=8, default build).
module tb_cr_crcgc_ob_buf;

    logic        clk = 1'b0;
    logic        rst;
    logic        sf_mode;
    logic        in_tvalid, in_tlast;
    logic [7:0]  in_tuser, in_tstrb;
    logic [63:0] in_tdata;
    logic        in_tready;
    logic        out_tvalid, out_tlast;
    logic [7:0]  out_tuser, out_tstrb;
    logic [63:0] out_tdata;
    logic        out_tready;
    logic [3:0]  fill_level;
    logic        stat_frame_out, stat_stall;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cr_crcgc_ob_buf #(.DEPTH(8)) dut (
        .clk(clk), .rst(rst), .sf_mode(sf_mode),
        .in_tvalid(in_tvalid), .in_tlast(in_tlast), .in_tuser(in_tuser),
        .in_tstrb(in_tstrb), .in_tdata(in_tdata), .in_tready(in_tready),
        .out_tvalid(out_tvalid), .out_tlast(out_tlast), .out_tuser(out_tuser),
        .out_tstrb(out_tstrb), .out_tdata(out_tdata), .out_tready(out_tready),
        .fill_level(fill_level), .stat_frame_out(stat_frame_out), .stat_stall(stat_stall)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [63:0] d, input logic l);
        in_tvalid = v;
        in_tdata  = d;
        in_tlast  = l;
        in_tuser  = d[7:0] ^ 8'h5A;
        in_tstrb  = 8'hFF;
    endtask

    initial begin
        rst = 1'b1; sf_mode = 1'b0; out_tready = 1'b1;
        drive(1'b0, 64'h0, 1'b0);
        #2;
        check("rst_in_tready", in_tready, 1);
        check("rst_out_tvalid", out_tvalid, 0);
        check("rst_fill", fill_level, 0);
        check("rst_frame_out", stat_frame_out, 0);
        check("rst_stall", stat_stall, 0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // cut-through 3-beat frame
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 64'(8'h11 * (i + 1)), i == 2);
            #1;
            check("ct_in_tready", in_tready, 1);
            if (i == 0) begin
                check("ct_first_valid", out_tvalid, 0);
            end else begin
                check("ct_valid", out_tvalid, 1);
                check("ct_data", out_tdata, 64'(8'h11 * i));
                check("ct_user", out_tuser, 64'((8'h11 * i) ^ 8'h5A));
                check("ct_fill", fill_level, 1);
                check("ct_no_frame", stat_frame_out, 0);
            end
            tick();
        end
        drive(1'b0, 64'h0, 1'b0);
        #1;
        check("ct_last_data", out_tdata, 64'h33);
        check("ct_last_tlast", out_tlast, 1);
        check("ct_frame_pulse", stat_frame_out, 1);
        check("ct_fill_last", fill_level, 1);
        tick();
        check("ct_drained_valid", out_tvalid, 0);
        check("ct_drained_fill", fill_level, 0);

        // store-and-forward 4-beat frame
        sf_mode = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 64'(8'hA0 + i), i == 3);
            #1;
            check("sf_hold_valid", out_tvalid, 0);
            check("sf_fill_grow", fill_level, 64'(i));
            tick();
        end
        drive(1'b0, 64'h0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            #1;
            check("sf_valid", out_tvalid, 1);
            check("sf_data", out_tdata, 64'(8'hA0 + k));
            check("sf_fill", fill_level, 64'(4 - k));
            check("sf_frame_pulse", stat_frame_out, 64'(k == 3));
            tick();
        end
        check("sf_done_valid", out_tvalid, 0);

        // store-and-forward 12-beat frame, starts with backpressure
        out_tready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 64'(8'hC0 + i), 1'b0);
            #1;
            check("big_hold_valid", out_tvalid, 0);
            check("big_in_tready", in_tready, 1);
            tick();
        end
        drive(1'b1, 64'hC8, 1'b0);
        #1;
        check("big_full_tready", in_tready, 0);
        check("big_full_fill", fill_level, 8);
        check("big_full_valid", out_tvalid, 1);
        check("big_full_stall", stat_stall, 1);
        check("big_full_data", out_tdata, 64'hC0);
        tick();
        out_tready = 1'b1;
        #1;
        check("full_pop_tready", in_tready, 0);
        check("full_pop_fill", fill_level, 8);
        check("full_pop_data", out_tdata, 64'hC0);
        tick();
        for (int k = 1; k < 12; k++) begin
            if (k <= 4) drive(1'b1, 64'(8'hC7 + k), k == 4);
            else        drive(1'b0, 64'h0, 1'b0);
            #1;
            if (k == 1) check("full_next_tready", in_tready, 1);
            check("big_valid", out_tvalid, 1);
            check("big_data", out_tdata, 64'(8'hC0 + k));
            check("big_tlast", out_tlast, 64'(k == 11));
            check("big_fill", fill_level, (k <= 5) ? 64'd7 : 64'(12 - k));
            tick();
        end
        check("big_done_valid", out_tvalid, 0);
        check("big_done_fill", fill_level, 0);

        // backpressure stability and sf_mode toggle while valid
        sf_mode = 1'b0;
        tick();
        out_tready = 1'b0;
        drive(1'b1, 64'hBEEF, 1'b0);
        #1;
        check("bp_pre_valid", out_tvalid, 0);
        tick();
        drive(1'b0, 64'h0, 1'b0);
        sf_mode = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            check("bp_valid", out_tvalid, 1);
            check("bp_data", out_tdata, 64'hBEEF);
            check("bp_user", out_tuser, 64'(8'hEF ^ 8'h5A));
            check("bp_stall", stat_stall, 1);
            tick();
        end
        sf_mode = 1'b0;
        out_tready = 1'b1;
        #1;
        check("bp_release_data", out_tdata, 64'hBEEF);
        check("bp_release_stall", stat_stall, 0);
        tick();
        drive(1'b1, 64'hF00D, 1'b1);
        #1;
        check("xfer_empty_valid", out_tvalid, 0);
        check("xfer_empty_fill", fill_level, 0);
        tick();
        drive(1'b0, 64'h0, 1'b0);
        #1;
        check("xfer_tail_valid", out_tvalid, 1);
        check("xfer_tail_data", out_tdata, 64'hF00D);
        check("xfer_tail_pulse", stat_frame_out, 1);
        tick();

        // reset mid-frame with 5 beats stored
        out_tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 64'(8'h50 + i), 1'b0);
            tick();
        end
        drive(1'b0, 64'h0, 1'b0);
        #1;
        check("mid_fill", fill_level, 5);
        check("mid_valid", out_tvalid, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", out_tvalid, 0);
        check("mid_rst_fill", fill_level, 0);
        check("mid_rst_tready", in_tready, 1);
        check("mid_rst_stall", stat_stall, 0);
        tick();
        rst = 1'b0;
        sf_mode = 1'b1;
        out_tready = 1'b1;
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 64'(8'h61 + i), i == 1);
            #1;
            check("post_hold_valid", out_tvalid, 0);
            tick();
        end
        drive(1'b0, 64'h0, 1'b0);
        #1;
        check("post_valid", out_tvalid, 1);
        check("post_data0", out_tdata, 64'h61);
        check("post_fill", fill_level, 2);
        tick();
        check("post_data1", out_tdata, 64'h62);
        check("post_pulse", stat_frame_out, 1);
        tick();
        check("post_done_valid", out_tvalid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
